// File: rtl/y86_mem_arb_pkg.sv
// Shared types and sizes for the Y86-64 unified memory arbiter.
package y86_mem_arb_pkg;

  localparam int unsigned BEAT_BYTES  = 8;
  localparam int unsigned INSTR_BYTES = 10;
  localparam int unsigned ADDR_W      = 64;
  localparam int unsigned DATA_W      = 8 * BEAT_BYTES;
  localparam int unsigned INSTR_W     = 8 * INSTR_BYTES;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DM_ACC,
    ST_IF_B0,
    ST_IF_B1,
    ST_RESP
  } arb_state_e;

  // Backend command payload presented on mem_we/mem_addr/mem_wdata.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arb_timer.sv
// Per-beat timeout counter: cleared at beat start, counts waiting cycles.
module mem_arb_timer #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic run,
  output logic expired_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  // Waiting-cycle counter; load restarts it for a new beat.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (run) begin
      count <= count + CNT_W'(1);
    end
  end

  // Fires on the waiting cycle that would bring the count to TIMEOUT.
  assign expired_c = run && (count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/y86_mem_arbiter.sv
// Arbitrates fetch and data requests onto one 64-bit single-ported memory.
module y86_mem_arbiter
  import y86_mem_arb_pkg::*;
#(
  parameter int unsigned MEM_SIZE = 4096,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic               if_ack,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_err,
  input  logic               dm_req,
  input  logic               dm_we,
  input  logic [ADDR_W-1:0]  dm_addr,
  input  logic [DATA_W-1:0]  dm_wdata,
  output logic               dm_ack,
  output logic [DATA_W-1:0]  dm_rdata,
  output logic               dm_err,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic               mem_ack,
  input  logic [DATA_W-1:0]  mem_rdata
);

  localparam logic [ADDR_W-1:0] DM_LAST = ADDR_W'(MEM_SIZE - BEAT_BYTES);
  localparam logic [ADDR_W-1:0] IF_LAST = ADDR_W'(MEM_SIZE - INSTR_BYTES);

  arb_state_e         state_q, state_d;
  logic               last_dm_q, last_dm_d;
  mem_cmd_t           cmd_q, cmd_d;
  logic [DATA_W-1:0]  beat0_q, beat0_d;
  logic               mem_req_d;
  logic               if_ack_d, if_err_d, dm_ack_d, dm_err_d;
  logic [INSTR_W-1:0] if_instr_d;
  logic [DATA_W-1:0]  dm_rdata_d;
  logic               grant_dm;
  logic               timer_load, timer_run, timer_expired;

  mem_arb_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (timer_load),
    .run       (timer_run),
    .expired_c (timer_expired)
  );

  assign mem_we    = cmd_q.we;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      last_dm_q <= 1'b0;
      cmd_q     <= '0;
      beat0_q   <= '0;
      mem_req   <= 1'b0;
      if_ack    <= 1'b0;
      if_instr  <= '0;
      if_err    <= 1'b0;
      dm_ack    <= 1'b0;
      dm_rdata  <= '0;
      dm_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_dm_q <= last_dm_d;
      cmd_q     <= cmd_d;
      beat0_q   <= beat0_d;
      mem_req   <= mem_req_d;
      if_ack    <= if_ack_d;
      if_instr  <= if_instr_d;
      if_err    <= if_err_d;
      dm_ack    <= dm_ack_d;
      dm_rdata  <= dm_rdata_d;
      dm_err    <= dm_err_d;
    end
  end

  // Grant, beat sequencing, range/timeout errors and response formation.
  always_comb begin
    state_d    = state_q;
    last_dm_d  = last_dm_q;
    cmd_d      = cmd_q;
    beat0_d    = beat0_q;
    mem_req_d  = mem_req;
    if_ack_d   = 1'b0;
    if_instr_d = if_instr;
    if_err_d   = if_err;
    dm_ack_d   = 1'b0;
    dm_rdata_d = dm_rdata;
    dm_err_d   = dm_err;
    grant_dm   = 1'b0;
    timer_load = 1'b0;
    timer_run  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        grant_dm = dm_req && (!if_req || !last_dm_q);
        if (grant_dm) begin
          if (dm_addr > DM_LAST) begin
            state_d    = ST_RESP;
            last_dm_d  = 1'b1;
            dm_ack_d   = 1'b1;
            dm_err_d   = 1'b1;
            dm_rdata_d = '0;
          end else begin
            state_d     = ST_DM_ACC;
            mem_req_d   = 1'b1;
            cmd_d.we    = dm_we;
            cmd_d.addr  = dm_addr;
            cmd_d.wdata = dm_wdata;
            timer_load  = 1'b1;
          end
        end else if (if_req) begin
          if (if_addr > IF_LAST) begin
            state_d    = ST_RESP;
            last_dm_d  = 1'b0;
            if_ack_d   = 1'b1;
            if_err_d   = 1'b1;
            if_instr_d = '0;
          end else begin
            state_d     = ST_IF_B0;
            mem_req_d   = 1'b1;
            cmd_d.we    = 1'b0;
            cmd_d.addr  = if_addr;
            cmd_d.wdata = '0;
            timer_load  = 1'b1;
          end
        end
      end

      ST_DM_ACC: begin
        timer_run = !mem_ack;
        if (mem_ack || timer_expired) begin
          state_d    = ST_RESP;
          mem_req_d  = 1'b0;
          last_dm_d  = 1'b1;
          dm_ack_d   = 1'b1;
          dm_err_d   = !mem_ack;
          dm_rdata_d = (mem_ack && !cmd_q.we) ? mem_rdata : '0;
        end
      end

      ST_IF_B0: begin
        timer_run = !mem_ack;
        if (mem_ack) begin
          state_d    = ST_IF_B1;
          beat0_d    = mem_rdata;
          cmd_d.addr = cmd_q.addr + ADDR_W'(BEAT_BYTES);
          timer_load = 1'b1;
        end else if (timer_expired) begin
          state_d    = ST_RESP;
          mem_req_d  = 1'b0;
          last_dm_d  = 1'b0;
          if_ack_d   = 1'b1;
          if_err_d   = 1'b1;
          if_instr_d = '0;
        end
      end

      ST_IF_B1: begin
        timer_run = !mem_ack;
        if (mem_ack || timer_expired) begin
          state_d    = ST_RESP;
          mem_req_d  = 1'b0;
          last_dm_d  = 1'b0;
          if_ack_d   = 1'b1;
          if_err_d   = !mem_ack;
          if_instr_d = mem_ack ? {mem_rdata[15:0], beat0_q} : '0;
        end
      end

      ST_RESP: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_y86_mem_arbiter.sv
// Scoreboard bench for y86_mem_arbiter with a scripted backend memory model.
module tb_y86_mem_arbiter;

  localparam int unsigned MEM_SIZE = 4096;
  localparam int unsigned TIMEOUT  = 15;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req, if_ack, if_err;
  logic [63:0] if_addr;
  logic [79:0] if_instr;
  logic        dm_req, dm_we, dm_ack, dm_err;
  logic [63:0] dm_addr, dm_wdata, dm_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  y86_mem_arbiter #(.MEM_SIZE(MEM_SIZE), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_instr(if_instr), .if_err(if_err),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .dm_err(dm_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       tag;
    bit          is_dm;
    logic [79:0] data;
    bit          err;
    int unsigned obs;
  } exp_t;

  typedef struct {
    string       name;
    logic [79:0] got;
    logic [79:0] exp;
  } dchk_t;

  exp_t  sb[$];
  dchk_t dq[$];
  int    n_checks = 0;
  int    n_pass   = 0;

  // Backend model controls and memory image.
  logic [63:0] bk_mem [logic [63:0]];
  int unsigned bk_delay = 0;
  bit          bk_never = 0;
  int unsigned bk_cnt   = 0;
  int unsigned req_cycles = 0;

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Monitor: evaluates queued direct checks and scores every ack against the scoreboard.
  initial begin
    dchk_t d;
    exp_t  e;
    forever begin
      @(negedge clk);
      while (dq.size() > 0) begin
        d = dq.pop_front();
        chk(d.name, d.got, d.exp);
      end
      if (dm_ack || if_ack) begin
        if (sb.size() == 0) begin
          chk("unexpected_ack", {78'b0, if_ack, dm_ack}, 80'b0);
        end else begin
          e = sb.pop_front();
          chk({e.tag, "_onehot"}, {79'b0, dm_ack & if_ack}, 80'b0);
          chk({e.tag, "_kind"}, {79'b0, dm_ack}, {79'b0, e.is_dm});
          chk({e.tag, "_cycle"}, 80'(cyc), 80'(e.obs));
          chk({e.tag, "_data"}, e.is_dm ? {16'b0, dm_rdata} : if_instr, e.data);
          chk({e.tag, "_err"}, {79'b0, e.is_dm ? dm_err : if_err}, {79'b0, e.err});
        end
      end
    end
  end

  // Backend: acks each beat after bk_delay wait cycles unless bk_never is set.
  initial begin
    bk_mem[64'h40]  = 64'h1122334455667788;
    bk_mem[64'h10]  = 64'h0706050403020100;
    bk_mem[64'h18]  = 64'h0F0E0D0C0B0A0908;
    bk_mem[64'd4086] = 64'h8877665544332211;
    bk_mem[64'd4094] = 64'hFFFFFFFFFFFFBBAA;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (!mem_req) begin
        mem_ack = 1'b0;
        bk_cnt  = 0;
      end else if (!bk_never && bk_cnt >= bk_delay) begin
        mem_ack = 1'b1;
        bk_cnt  = 0;
        if (mem_we) begin
          bk_mem[mem_addr] = mem_wdata;
          mem_rdata = 64'hBAD0BAD0BAD0BAD0;
        end else begin
          mem_rdata = bk_mem.exists(mem_addr) ? bk_mem[mem_addr] : 64'hA5A5A5A5A5A5A5A5;
        end
      end else begin
        mem_ack   = 1'b0;
        bk_cnt++;
        mem_rdata = 64'hDEAD00000000DEAD;
      end
    end
  end

  task automatic dcheck(input string name, input logic [79:0] got, input logic [79:0] exp);
    dchk_t d;
    d.name = name;
    d.got  = got;
    d.exp  = exp;
    dq.push_back(d);
  endtask

  task automatic push_exp(input string tag, input bit is_dm, input logic [79:0] data,
                          input bit err, input int unsigned obs);
    exp_t e;
    e.tag = tag; e.is_dm = is_dm; e.data = data; e.err = err; e.obs = obs;
    sb.push_back(e);
  endtask

  // Waits (bounded) until the monitor has consumed every expected response.
  task automatic wait_drain(input string tag, input int unsigned budget);
    req_cycles = 0;
    for (int i = 0; i < int'(budget); i++) begin
      @(negedge clk);
      #1;
      if (mem_req) req_cycles++;
      if (sb.size() == 0) break;
    end
    if (sb.size() != 0) begin
      dcheck({tag, "_no_ack"}, 80'(sb.size()), 80'b0);
      sb.delete();
    end
  endtask

  // lat is the cycle (1 = cycle after the grant edge) in which the ack must appear.
  task automatic dm_txn(input string tag, input bit we, input logic [63:0] a,
                        input logic [63:0] wd, input logic [63:0] exp_rd,
                        input bit exp_err, input int unsigned lat);
    int unsigned g;
    @(negedge clk);
    #1;
    g = cyc + 1;
    push_exp(tag, 1'b1, {16'b0, exp_rd}, exp_err, g + lat - 1);
    dm_we = we; dm_addr = a; dm_wdata = wd; dm_req = 1'b1;
    wait_drain(tag, 40);
    dm_req = 1'b0;
  endtask

  task automatic if_txn(input string tag, input logic [63:0] a,
                        input logic [79:0] exp_instr, input bit exp_err,
                        input int unsigned lat);
    int unsigned g;
    @(negedge clk);
    #1;
    g = cyc + 1;
    push_exp(tag, 1'b0, exp_instr, exp_err, g + lat - 1);
    if_addr = a; if_req = 1'b1;
    wait_drain(tag, 40);
    if_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench hang");
  end

  // Directed stimulus.
  initial begin
    int unsigned g;
    reset_n = 1'b0;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (2) @(negedge clk);
    #1;
    dcheck("rst_ctrl", {74'b0, mem_req, mem_we, if_ack, dm_ack, if_err, dm_err}, 80'b0);
    dcheck("rst_mem_addr", {16'b0, mem_addr}, 80'b0);
    dcheck("rst_mem_wdata", {16'b0, mem_wdata}, 80'b0);
    dcheck("rst_if_instr", if_instr, 80'b0);
    dcheck("rst_dm_rdata", {16'b0, dm_rdata}, 80'b0);
    reset_n = 1'b1;

    dm_txn("dm_rd40", 1'b0, 64'h40, 64'h0, 64'h1122334455667788, 1'b0, 2);
    if_txn("if_10", 64'h10, 80'h09080706050403020100, 1'b0, 3);
    dm_txn("dm_wr80", 1'b1, 64'h80, 64'hCAFEF00D12345678, 64'h0, 1'b0, 2);
    dcheck("wr80_stored", {16'b0, bk_mem.exists(64'h80) ? bk_mem[64'h80] : 64'h0},
           {16'b0, 64'hCAFEF00D12345678});
    dm_txn("dm_rd80", 1'b0, 64'h80, 64'h0, 64'hCAFEF00D12345678, 1'b0, 2);

    bk_delay = 2;
    dm_txn("dm_wait2", 1'b0, 64'h40, 64'h0, 64'h1122334455667788, 1'b0, 4);
    bk_delay = 1;
    if_txn("if_wait1", 64'h10, 80'h09080706050403020100, 1'b0, 5);
    bk_delay = 0;

    dm_txn("dm_range", 1'b0, 64'd4092, 64'h0, 64'h0, 1'b1, 1);
    dcheck("dm_range_no_memreq", 80'(req_cycles), 80'd0);
    dm_txn("dm_edge", 1'b0, 64'd4088, 64'h0, 64'hA5A5A5A5A5A5A5A5, 1'b0, 2);
    if_txn("if_range", 64'd4087, 80'h0, 1'b1, 1);
    dcheck("if_range_no_memreq", 80'(req_cycles), 80'd0);
    if_txn("if_edge", 64'd4086, 80'hBBAA8877665544332211, 1'b0, 3);

    bk_never = 1'b1;
    dm_txn("dm_tmo", 1'b0, 64'h100, 64'h0, 64'h0, 1'b1, 16);
    dcheck("dm_tmo_req_cycles", 80'(req_cycles), 80'd15);
    bk_never = 1'b0;

    // Last grant is a fetch, so with both pending data wins first, then alternation.
    if_txn("if_pre_alt", 64'h10, 80'h09080706050403020100, 1'b0, 3);
    @(negedge clk);
    #1;
    g = cyc + 1;
    push_exp("alt0_dm", 1'b1, {16'b0, 64'h1122334455667788}, 1'b0, g + 1);
    push_exp("alt1_if", 1'b0, 80'h09080706050403020100, 1'b0, g + 5);
    push_exp("alt2_dm", 1'b1, {16'b0, 64'h1122334455667788}, 1'b0, g + 8);
    push_exp("alt3_if", 1'b0, 80'h09080706050403020100, 1'b0, g + 12);
    dm_we = 1'b0; dm_addr = 64'h40; if_addr = 64'h10;
    dm_req = 1'b1; if_req = 1'b1;
    wait_drain("alt", 40);
    dm_req = 1'b0; if_req = 1'b0;

    // Reset asserted during the second fetch beat.
    @(negedge clk);
    #1;
    if_addr = 64'h10; if_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    if_req  = 1'b0;
    #1;
    dcheck("rst_mid_ctrl", {77'b0, mem_req, if_ack, dm_ack}, 80'b0);
    dcheck("rst_mid_addr", {16'b0, mem_addr}, 80'b0);
    dcheck("rst_mid_instr", if_instr, 80'b0);
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b1;
    if_txn("if_after_rst", 64'h10, 80'h09080706050403020100, 1'b0, 3);

    @(negedge clk);
    #1;
    dcheck("sb_empty", 80'(sb.size()), 80'b0);
    repeat (3) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
